bus_requester: RTL and testbench
================================

# bus_requester

Client-side agent for the 4-way round-robin arbiter on the shared bus. It buffers locally written data words in a small FIFO and drives one of the arbiter's REQ lines. While its GRANT line is high, it presents buffered words as bus beats, and pulses ACK on the final beat of a burst to hand the bus back. One instance sits on each of the arbiter's four requester ports. Each instance connects to its own REQ[i]/GRANT[i] bit and to the shared ACK through an OR of all requesters' ACKs.

## Interface
- DW, 8: data word width.
- DEPTH, 8: FIFO depth; power of two, ≥2.
- MAX_BURST, 4: maximum beats per grant; 1..DEPTH.

Ports:
- CLK  in  1  rising-edge clock.
- SCLR_N  in  1  reset; one clock, reset is synchronous and active-low.
- WR_EN  in  1  push WR_DATA into FIFO.
- WR_DATA  in  DW  word to push.
- FULL  out  1  FIFO holds DEPTH words.
- COUNT  out  clog2(DEPTH)+1  FIFO occupancy.
- REQ  out  1  bus request to arbiter.
- GRANT  in  1  this requester's grant bit from arbiter.
- ACK  out  1  burst-complete pulse to arbiter.
- BUS_VALID  out  1  beat present on BUS_DATA this cycle.
- BUS_DATA  out  DW  FIFO head when BUS_VALID, else 0.
- PREEMPT_CNT  out  16  only with BUS_REQUESTER_STATS_EN.

## Operation
- The FSM has two states, IDLE and WAIT. WAIT covers both the requesting and the owning phases, which are distinguished only by GRANT.
- FIFO push rules:
  - Push happens when WR_EN=1 and FULL=0.
  - If FULL=1, WR_EN is ignored, even when a pop occurs in the same cycle.
  - There is no bypass: a word pushed in cycle N cannot be a beat before cycle N+1.
- Beat rule: beat = (state==WAIT) & GRANT & (COUNT>0) & (beat_cnt<MAX_BURST).
  - BUS_VALID = beat.
  - A beat pops the FIFO head and increments beat_cnt.
- ACK = beat & ((COUNT==1) | (beat_cnt==MAX_BURST-1)).
  - This is combinational from the registered state and GRANT. There is no loop, because GRANT is a registered decode inside the arbiter.
  - A simultaneous push when COUNT==1 still ends the burst.
- REQ = (state==WAIT) & ~ACK.
  - REQ drops in the ACK cycle so the arbiter does not re-grant this requester on the same edge.
- State transitions:
  - IDLE → WAIT when COUNT>0.
  - WAIT → IDLE on ACK if the FIFO is empty after the edge.
  - WAIT stays in WAIT on ACK if words remain, and REQ reasserts the next cycle.
- beat_cnt clears:
  - on ACK;
  - in any cycle with GRANT=0;
  - in IDLE.
- Preemption: GRANT falling in WAIT without a preceding ACK (arbiter time-out) leaves the unsent words in the FIFO. REQ stays high, and the next grant starts a fresh burst of up to MAX_BURST beats.
- GRANT=1 while in IDLE is ignored: no beats, REQ=0.
- beat_cnt width: clog2(MAX_BURST)+1.
- COUNT arithmetic: +1 on push, −1 on pop, unchanged on simultaneous push+pop. Pointers wrap modulo DEPTH.

## Timing
- Reset: SCLR_N=0 at an edge causes the following.
  - State = IDLE, FIFO emptied, beat_cnt=0, PREEMPT_CNT=0.
  - Outputs REQ=0, ACK=0, BUS_VALID=0, BUS_DATA=0, FULL=0, COUNT=0.
  - Reset mid-burst discards buffered words. The arbiter sees REQ=0 and ACK=0 from the next cycle.
- Latency with the arbiter idle and no competitors:
  - edge E: push; COUNT=1 after E.
  - edge E+1: state goes to WAIT; REQ=1 after E+1.
  - edge E+2: arbiter samples REQ; GRANT=1 after E+2.
  - cycle after E+2: first beat.
- One beat per cycle while granted. ACK coincides with the last beat.
- The arbiter sees ACK at the edge ending the last beat. GRANT falls the next cycle.
- Beats are valid only in cycles where GRANT=1. Beats in the cycle where the arbiter's time-out fires are valid, since GRANT falls one cycle later.

## Configuration
- BUS_REQUESTER_STATS_EN defined:
  - Adds the PREEMPT_CNT port.
  - PREEMPT_CNT is a 16-bit saturating count of cycles where GRANT was 1 in WAIT with no ACK, and GRANT is 0 in the following cycle.
  - It saturates at 0xFFFF and clears on reset.
- BUS_REQUESTER_STATS_EN undefined: no port and no counter logic.

## Test plan
- Reset: hold SCLR_N=0 with WR_EN=1 and GRANT=1 → REQ=0, ACK=0, BUS_VALID=0, COUNT=0 throughout.
- Single word: push 0xA5, model GRANT as arbiter-registered → REQ high 1 cycle after push; one beat 0xA5 with ACK=1 in the same cycle; REQ=0 in that cycle; state returns to IDLE.
- Burst split: push 6 words 0x01..0x06, continuous grant → first grant carries beats 0x01..0x04 with ACK on 0x04; REQ reasserts; second grant carries 0x05..0x06 with ACK on 0x06.
- Preemption: push 4 words, GRANT high for 2 cycles then low without ACK → 0x01, 0x02 sent; COUNT=2; REQ stays 1; regrant sends 0x03, 0x04 with ACK on 0x04; PREEMPT_CNT=1 with the macro.
- FIFO boundaries: push 9 words with no grant → FULL=1 after 8; 9th word dropped; push while FULL and popping is also dropped; COUNT never exceeds 8.
- Spurious grant: GRANT=1 while IDLE and FIFO empty → BUS_VALID=0, ACK=0, REQ=0.

Source files
------------

// File: rtl/bus_requester.sv
// Purpose : client-side requester for the shared 4-way round-robin bus; buffers written words and bursts them out while granted.
// Latency : a word pushed at edge E raises REQ after E+1; first beat in the cycle after GRANT rises; no write-to-bus bypass.
// Backpres: WR_EN is dropped while FULL (even with a same-cycle pop); bursts end with ACK after MAX_BURST beats or when the FIFO drains.
//
// Ports:
//   CLK, SCLR_N          clock, synchronous active-low reset
//   WR_EN, WR_DATA       local write into the FIFO
//   FULL, COUNT          FIFO status (COUNT is the occupancy)
//   REQ, GRANT, ACK      arbiter handshake (GRANT is registered inside the arbiter)
//   BUS_VALID, BUS_DATA  bus beat; BUS_DATA is zero when no beat
//   PREEMPT_CNT          saturating count of grants withdrawn without ACK
//                        (present only when BUS_REQUESTER_STATS_EN is defined)

module bus_requester #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     CLK,
    input  logic                     SCLR_N,
    input  logic                     WR_EN,
    input  logic [DW-1:0]            WR_DATA,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     REQ,
    input  logic                     GRANT,
    output logic                     ACK,
    output logic                     BUS_VALID,
    output logic [DW-1:0]            BUS_DATA
`ifdef BUS_REQUESTER_STATS_EN
    ,
    output logic [15:0]              PREEMPT_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    // WAIT spans both requesting and owning the bus; GRANT tells them apart.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   beat_cnt;

    logic            push;
    logic            beat;
    logic            ack;
    logic [CW-1:0]   count_nxt;

    always_comb begin
        // FULL blocks the push even if a beat frees a slot this cycle.
        push      = WR_EN & (count != CW'(DEPTH));
        beat      = (state == WAIT) & GRANT & (count != '0) &
                    (beat_cnt < BW'(MAX_BURST));
        // Burst ends on the last buffered word or on the burst limit; a
        // same-cycle push does not extend it.
        ack       = beat & ((count == CW'(1)) | (beat_cnt == BW'(MAX_BURST - 1)));
        count_nxt = count + CW'(push) - CW'(beat);
    end

    // Pointers are AW bits wide, so DEPTH being a power of two makes them wrap.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (beat) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;

            if (state == IDLE) begin
                if (count != '0) begin
                    state <= WAIT;
                end
            end else begin
                // With words left we stay in WAIT and REQ comes back next cycle.
                if (ack && (count_nxt == '0)) begin
                    state <= IDLE;
                end
            end

            // A withdrawn grant (pre-emption) restarts the burst budget.
            if ((state == IDLE) || !GRANT || ack) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end

`ifdef BUS_REQUESTER_STATS_EN
    // own_q: last cycle we held the grant and did not hand it back.
    logic own_q;

    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            own_q       <= 1'b0;
            PREEMPT_CNT <= '0;
        end else begin
            own_q <= (state == WAIT) & GRANT & ~ack;
            if (own_q && !GRANT && (PREEMPT_CNT != 16'hFFFF)) begin
                PREEMPT_CNT <= PREEMPT_CNT + 16'd1;
            end
        end
    end
`endif

    assign FULL      = (count == CW'(DEPTH));
    assign COUNT     = count;
    assign REQ       = (state == WAIT) & ~ack;
    assign ACK       = ack;
    assign BUS_VALID = beat;
    assign BUS_DATA  = beat ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_bus_requester.sv
// Purpose : self-checking bench for bus_requester using a per-cycle vector table and a data scoreboard.
// Latency : rows driven 1 ns after the rising edge, outputs compared on the falling edge.
// Backpres: GRANT follows the table (arbiter-registered timing), then a small arbiter model for the hand-written sequence.

module tb_bus_requester;

    localparam int DW        = 8;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;

    logic                   CLK;
    logic                   SCLR_N;
    logic                   WR_EN;
    logic [DW-1:0]          WR_DATA;
    logic                   FULL;
    logic [$clog2(DEPTH):0] COUNT;
    logic                   REQ;
    logic                   GRANT;
    logic                   ACK;
    logic                   BUS_VALID;
    logic [DW-1:0]          BUS_DATA;
`ifdef BUS_REQUESTER_STATS_EN
    logic [15:0]            PREEMPT_CNT;
`endif

    bus_requester #(.DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .CLK       (CLK),
        .SCLR_N    (SCLR_N),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .FULL      (FULL),
        .COUNT     (COUNT),
        .REQ       (REQ),
        .GRANT     (GRANT),
        .ACK       (ACK),
        .BUS_VALID (BUS_VALID),
        .BUS_DATA  (BUS_DATA)
`ifdef BUS_REQUESTER_STATS_EN
        ,
        .PREEMPT_CNT (PREEMPT_CNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit          sclr_n;
        bit          we;
        logic [7:0]  wd;
        bit          g;
        bit          chk;
        bit          req;
        bit          ack;
        bit          vld;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  sb[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got 0x%0h want 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit s, input bit we, input logic [7:0] wd, input bit g,
                       input bit chk, input bit req, input bit ack, input bit vld);
        vec_t v;
        v = '{s, we, wd, g, chk, req, ack, vld};
        vecs.push_back(v);
    endtask

    // Beat data check against the scoreboard head; an empty scoreboard is a failure.
    task automatic check_beat(input string nm, input int idx);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s @%0d: beat 0x%0h with no word expected", nm, idx, BUS_DATA);
        end else if (BUS_DATA !== sb[0]) begin
            errors++;
            $display("FAIL %s @%0d: got 0x%0h want 0x%0h", nm, idx, BUS_DATA, sb[0]);
        end
    endtask

    initial begin
        bit   acc;
        bit   g_next;
        int   beats;
        int   acks;
        int   first_k;

        SCLR_N  = 1'b0;
        WR_EN   = 1'b0;
        WR_DATA = '0;
        GRANT   = 1'b0;

        // reset held with WR_EN and GRANT high
        add(0, 1, 8'hEE, 1, 0, 0, 0, 0);
        add(0, 1, 8'hEE, 1, 1, 0, 0, 0);
        add(0, 1, 8'hEE, 1, 1, 0, 0, 0);
        // spurious grant while idle and empty
        add(1, 0, 8'h00, 1, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        // single word
        add(1, 1, 8'hA5, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        // burst split: 6 words, MAX_BURST 4 then 2
        add(1, 1, 8'h01, 0, 1, 0, 0, 0);
        add(1, 1, 8'h02, 0, 1, 0, 0, 0);
        add(1, 1, 8'h03, 0, 1, 1, 0, 0);
        add(1, 1, 8'h04, 1, 1, 1, 0, 1);
        add(1, 1, 8'h05, 1, 1, 1, 0, 1);
        add(1, 1, 8'h06, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        // pre-emption after two beats (rows 21..30)
        add(1, 1, 8'h11, 0, 1, 0, 0, 0);
        add(1, 1, 8'h12, 0, 1, 0, 0, 0);
        add(1, 1, 8'h13, 0, 1, 1, 0, 0);
        add(1, 1, 8'h14, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        // FIFO boundaries: 9 pushes with no grant, then push while full and popping
        for (int k = 0; k < 8; k++) begin
            add(1, 1, 8'h21 + 8'(k), 0, 1, (k >= 2), 0, 0);
        end
        add(1, 1, 8'h29, 0, 1, 1, 0, 0);
        add(1, 1, 8'h2A, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);
        // reset mid-burst discards the remaining word
        add(1, 1, 8'h31, 0, 1, 0, 0, 0);
        add(1, 1, 8'h32, 0, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1, 0, 1);
        add(1, 0, 8'h00, 1, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLK);
            #1;
            SCLR_N  = vecs[i].sclr_n;
            WR_EN   = vecs[i].we;
            WR_DATA = vecs[i].wd;
            GRANT   = vecs[i].g;
            @(negedge CLK);
            if (vecs[i].chk) begin
                check("REQ",       i, 32'(REQ),       32'(vecs[i].req));
                check("ACK",       i, 32'(ACK),       32'(vecs[i].ack));
                check("BUS_VALID", i, 32'(BUS_VALID), 32'(vecs[i].vld));
                check("COUNT",     i, 32'(COUNT),     32'(sb.size()));
                check("FULL",      i, 32'(FULL),      32'(sb.size() == DEPTH));
                if (vecs[i].vld) begin
                    check_beat("BUS_DATA", i);
                end else begin
                    check("BUS_DATA_IDLE", i, 32'(BUS_DATA), 32'h0);
                end
            end
`ifdef BUS_REQUESTER_STATS_EN
            if (i == 26) check("PREEMPT_CNT_PRE",  i, 32'(PREEMPT_CNT), 32'd0);
            if (i == 27) check("PREEMPT_CNT",      i, 32'(PREEMPT_CNT), 32'd1);
            if (i == 54) check("PREEMPT_CNT_RST",  i, 32'(PREEMPT_CNT), 32'd0);
`endif
            // scoreboard update for the coming edge: acceptance uses pre-pop occupancy
            acc = vecs[i].we && (sb.size() < DEPTH);
            if (vecs[i].vld && (sb.size() > 0)) void'(sb.pop_front());
            if (!vecs[i].sclr_n) sb.delete();
            else if (acc) sb.push_back(vecs[i].wd);
        end

        // Hand-written sequence: 3 words with an arbiter model (GRANT = REQ registered).
        g_next  = 1'b0;
        beats   = 0;
        acks    = 0;
        first_k = -1;
        for (int k = 0; k < 14; k++) begin
            @(posedge CLK);
            #1;
            SCLR_N  = 1'b1;
            WR_EN   = (k < 3);
            WR_DATA = 8'h40 + 8'(k);
            GRANT   = g_next;
            @(negedge CLK);
            acc = WR_EN && (sb.size() < DEPTH);
            if (BUS_VALID) begin
                if (first_k < 0) first_k = k;
                check_beat("ARB_DATA", k);
                beats++;
                check("ARB_ACK", k, 32'(ACK), 32'(beats == 3));
                if (ACK) acks++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (acc) sb.push_back(WR_DATA);
            g_next = REQ;
        end
        check("ARB_FIRST_BEAT", 100, 32'(first_k), 32'd3);
        check("ARB_BEATS",      101, 32'(beats),   32'd3);
        check("ARB_ACKS",       102, 32'(acks),    32'd1);
        check("ARB_COUNT_END",  103, 32'(COUNT),   32'd0);
        check("ARB_REQ_END",    104, 32'(REQ),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
